// File: rtl/loopback_mcnt_pkg.sv
// Shared types and constants for the loopback mux0 mcnt monitor.
// Optional watchdog is enabled with the LOOPBACK_MCNT_WATCHDOG_EN macro.
package loopback_mcnt_pkg;

    // Default widths and limits
    localparam int unsigned MCNT_W_DEF   = 48;
    localparam int unsigned ERR_W_DEF    = 12;
    localparam int unsigned TIMEOUT_DEF  = 4096;

    // Field widths inside status_out
    localparam int unsigned GAP_W        = 12;
    localparam int unsigned ERR_FIELD_W  = 16;

    // status_out bit positions
    localparam int unsigned LOCK_BIT     = 31;
    localparam int unsigned ARM_BIT      = 30;
    localparam int unsigned STALE_BIT    = 29;

    // Monitor state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } mon_state_e;

    // Assemble the status word seen by the OPB register
    function automatic logic [31:0] pack_status(
        input logic                   locked,
        input logic                   armed,
        input logic                   stale,
        input logic [ERR_FIELD_W-1:0] err,
        input logic [GAP_W-1:0]       gap
    );
        logic [31:0] word;
        word                            = '0;
        word[LOCK_BIT]                  = locked;
        word[ARM_BIT]                   = armed;
        word[STALE_BIT]                 = stale;
        word[GAP_W +: ERR_FIELD_W]      = err;
        word[GAP_W-1:0]                 = gap;
        return word;
    endfunction

endpackage

// File: rtl/loopback_mcnt_monitor_if.sv
// Header/result bundle between the mux0 datapath and the mcnt monitor.
// The monitor sits on the slave side; the datapath/bench drives the master side.
interface loopback_mcnt_monitor_if
    import loopback_mcnt_pkg::*;
#(
    parameter int unsigned MCNT_W = MCNT_W_DEF
);
    logic              arm;
    logic              hdr_valid;
    logic [MCNT_W-1:0] pkt_mcnt;
    logic [31:0]       mcnt_out;
    logic [31:0]       status_out;
    logic              seq_err;

    modport master (
        output arm,
        output hdr_valid,
        output pkt_mcnt,
        input  mcnt_out,
        input  status_out,
        input  seq_err
    );

    modport slave (
        input  arm,
        input  hdr_valid,
        input  pkt_mcnt,
        output mcnt_out,
        output status_out,
        output seq_err
    );
endinterface

// File: rtl/loopback_mcnt_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Used for the sequence-error count and the optional idle watchdog.
module mcnt_sat_counter
    import loopback_mcnt_pkg::*;
#(
    parameter int unsigned W = ERR_W_DEF
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/loopback_mcnt_monitor.sv
// mcnt sequence monitor for loopback mux0: tracks the header master counter,
// flags any header whose mcnt is not last+1 and exports mcnt/status words.
// Build option LOOPBACK_MCNT_WATCHDOG_EN adds an idle watchdog that drops lock
// after TIMEOUT cycles without a header and raises the stale flag.
module loopback_mcnt_monitor
    import loopback_mcnt_pkg::*;
#(
    parameter int unsigned MCNT_W  = MCNT_W_DEF,
    parameter int unsigned ERR_W   = ERR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    loopback_mcnt_monitor_if.slave  bus
);
    mon_state_e         state_q, state_d;
    logic [MCNT_W-1:0]  expected_q, expected_d;
    logic [31:0]        mcnt_q, mcnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               seq_err_q, seq_err_d;
    logic               stale_q, stale_d;

    logic               err_inc;
    logic               err_clr;
    logic               wd_expire;
    logic [ERR_W-1:0]   err_cnt;
    logic [MCNT_W-1:0]  pkt_next;
    logic [GAP_W-1:0]   pkt_gap;
    logic               in_seq;

    // Helpers shared by every header-accept path; modulo arithmetic makes
    // all-ones -> 0 an in-sequence step
    assign pkt_next = bus.pkt_mcnt + 1'b1;
    assign pkt_gap  = bus.pkt_mcnt[GAP_W-1:0] - expected_q[GAP_W-1:0];
    assign in_seq   = (bus.pkt_mcnt == expected_q);

    // Sequence-error counter, cleared by arm and saturating at all-ones
    mcnt_sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk     (user_clk),
        .srst    (user_rst),
        .clr_i   (err_clr),
        .inc_i   (err_inc),
        .count_o (err_cnt)
    );

`ifdef LOOPBACK_MCNT_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_inc;

    // Count only idle locked cycles; any header, arm or leaving LOCKED restarts it
    assign wd_inc = (state_q == ST_LOCKED) && !bus.hdr_valid && !bus.arm;

    mcnt_sat_counter #(
        .W (WD_W)
    ) u_wd_cnt (
        .clk     (user_clk),
        .srst    (user_rst),
        .clr_i   (!wd_inc),
        .inc_i   (wd_inc),
        .count_o (wd_cnt)
    );

    // The TIMEOUT-th consecutive idle cycle drops lock
    assign wd_expire = wd_inc && (wd_cnt == WD_W'(TIMEOUT - 1));
`else
    // TIMEOUT only matters when the watchdog is built in
    localparam int unsigned unused_timeout = TIMEOUT;

    assign wd_expire = 1'b0;
`endif

    // Next-state and datapath updates; arm overrides everything else
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        mcnt_d     = mcnt_q;
        gap_d      = gap_q;
        seq_err_d  = 1'b0;
        stale_d    = stale_q;
        err_inc    = 1'b0;
        err_clr    = 1'b0;

        if (bus.arm) begin
            err_clr = 1'b1;
            gap_d   = '0;
            if (bus.hdr_valid) begin
                // Header arriving with arm is the first header after arm
                state_d    = ST_LOCKED;
                expected_d = pkt_next;
                mcnt_d     = bus.pkt_mcnt[31:0];
                stale_d    = 1'b0;
            end else begin
                state_d    = ST_ARMED;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Headers are ignored until software arms the monitor
                end
                ST_ARMED: begin
                    if (bus.hdr_valid) begin
                        state_d    = ST_LOCKED;
                        expected_d = pkt_next;
                        mcnt_d     = bus.pkt_mcnt[31:0];
                        stale_d    = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (bus.hdr_valid) begin
                        mcnt_d  = bus.pkt_mcnt[31:0];
                        stale_d = 1'b0;
                        if (in_seq) begin
                            expected_d = expected_q + 1'b1;
                        end else begin
                            // Mismatch: record it and resync on this header
                            seq_err_d  = 1'b1;
                            err_inc    = 1'b1;
                            gap_d      = pkt_gap;
                            expected_d = pkt_next;
                        end
                    end else if (wd_expire) begin
                        state_d = ST_ARMED;
                        stale_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q    <= ST_IDLE;
            expected_q <= '0;
            mcnt_q     <= '0;
            gap_q      <= '0;
            seq_err_q  <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            mcnt_q     <= mcnt_d;
            gap_q      <= gap_d;
            seq_err_q  <= seq_err_d;
            stale_q    <= stale_d;
        end
    end

    assign bus.mcnt_out   = mcnt_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.status_out = pack_status(state_q == ST_LOCKED,
                                        state_q == ST_ARMED,
                                        stale_q,
                                        ERR_FIELD_W'(err_cnt),
                                        gap_q);
endmodule

// File: tb/tb_loopback_mcnt_monitor.sv
// Directed bench for loopback_mcnt_monitor: one default-width instance and one
// with a 2-bit error counter share the same stimulus; both use TIMEOUT=16.
module tb_loopback_mcnt_monitor;

    logic        user_clk;
    logic        user_rst;
    logic        arm_r;
    logic        hv_r;
    logic [47:0] pkt_r;

    int n_tests = 0;
    int n_fail  = 0;

    loopback_mcnt_monitor_if #(.MCNT_W(48)) bus_a ();
    loopback_mcnt_monitor_if #(.MCNT_W(48)) bus_b ();

    assign bus_a.arm       = arm_r;
    assign bus_a.hdr_valid = hv_r;
    assign bus_a.pkt_mcnt  = pkt_r;
    assign bus_b.arm       = arm_r;
    assign bus_b.hdr_valid = hv_r;
    assign bus_b.pkt_mcnt  = pkt_r;

    loopback_mcnt_monitor #(.MCNT_W(48), .ERR_W(12), .TIMEOUT(16)) dut_a (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .bus      (bus_a)
    );

    loopback_mcnt_monitor #(.MCNT_W(48), .ERR_W(2), .TIMEOUT(16)) dut_b (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .bus      (bus_b)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    typedef struct {
        logic        arm;
        logic        hv;
        logic [47:0] pkt;
        logic [31:0] mcnt;
        logic        lock;
        logic        armd;
        logic [11:0] gap;
        logic [15:0] err_a;
        logic [15:0] err_b;
        logic        seq;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic a, input logic h, input logic [47:0] p,
                                input logic [31:0] m, input logic l, input logic ar,
                                input logic [11:0] g, input logic [15:0] ea,
                                input logic [15:0] eb, input logic s);
        vec_t v;
        v.arm = a; v.hv = h; v.pkt = p; v.mcnt = m; v.lock = l; v.armd = ar;
        v.gap = g; v.err_a = ea; v.err_b = eb; v.seq = s;
        return v;
    endfunction

    function automatic logic [31:0] st(input logic l, input logic ar, input logic s,
                                       input logic [15:0] e, input logic [11:0] g);
        return {l, ar, s, 1'b0, e, g};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        logic [47:0] ones48;
        int          seq_a_cnt;
        int          seq_b_cnt;
        int          sat_b_cnt;
        logic [31:0] exp_wd;

        ones48    = '1;
        seq_a_cnt = 0;
        seq_b_cnt = 0;
        sat_b_cnt = 0;

        //           arm hv  pkt     mcnt        lk ar gap     ea  eb  seq
        vecs[0]  = mk(0, 1, 48'd50,   32'd0,       0, 0, 12'h000, 0,  0,  0);
        vecs[1]  = mk(1, 0, 48'd0,    32'd0,       0, 1, 12'h000, 0,  0,  0);
        vecs[2]  = mk(0, 1, 48'd100,  32'd100,     1, 0, 12'h000, 0,  0,  0);
        vecs[3]  = mk(0, 1, 48'd101,  32'd101,     1, 0, 12'h000, 0,  0,  0);
        vecs[4]  = mk(0, 1, 48'd102,  32'd102,     1, 0, 12'h000, 0,  0,  0);
        vecs[5]  = mk(0, 0, 48'd0,    32'd102,     1, 0, 12'h000, 0,  0,  0);
        vecs[6]  = mk(0, 1, 48'd110,  32'd110,     1, 0, 12'h007, 1,  1,  1);
        vecs[7]  = mk(0, 0, 48'd0,    32'd110,     1, 0, 12'h007, 1,  1,  0);
        vecs[8]  = mk(0, 1, 48'd111,  32'd111,     1, 0, 12'h007, 1,  1,  0);
        vecs[9]  = mk(1, 1, ones48,   32'hFFFFFFFF,1, 0, 12'h000, 0,  0,  0);
        vecs[10] = mk(0, 1, 48'd0,    32'd0,       1, 0, 12'h000, 0,  0,  0);
        vecs[11] = mk(0, 1, 48'd1,    32'd1,       1, 0, 12'h000, 0,  0,  0);
        vecs[12] = mk(1, 1, 48'd500,  32'd500,     1, 0, 12'h000, 0,  0,  0);
        vecs[13] = mk(0, 1, 48'd501,  32'd501,     1, 0, 12'h000, 0,  0,  0);
        vecs[14] = mk(0, 1, 48'd503,  32'd503,     1, 0, 12'h001, 1,  1,  1);
        vecs[15] = mk(0, 0, 48'd0,    32'd503,     1, 0, 12'h001, 1,  1,  0);
        vecs[16] = mk(0, 1, 48'd504,  32'd504,     1, 0, 12'h001, 1,  1,  0);
        vecs[17] = mk(0, 1, 48'd600,  32'd600,     1, 0, 12'h05F, 2,  2,  1);
        vecs[18] = mk(0, 1, 48'd700,  32'd700,     1, 0, 12'h063, 3,  3,  1);
        vecs[19] = mk(0, 1, 48'd800,  32'd800,     1, 0, 12'h063, 4,  3,  1);
        vecs[20] = mk(0, 1, 48'd900,  32'd900,     1, 0, 12'h063, 5,  3,  1);
        vecs[21] = mk(0, 1, 48'd1000, 32'd1000,    1, 0, 12'h063, 6,  3,  1);
        vecs[22] = mk(0, 1, 48'd1001, 32'd1001,    1, 0, 12'h063, 6,  3,  0);
        vecs[23] = mk(0, 1, 48'd1000, 32'd1000,    1, 0, 12'hFFE, 7,  3,  1);

        // Reset state
        user_rst = 1'b1;
        arm_r    = 1'b0;
        hv_r     = 1'b0;
        pkt_r    = '0;
        repeat (3) step();
        chk("reset mcnt_a",   bus_a.mcnt_out,   32'd0);
        chk("reset status_a", bus_a.status_out, 32'd0);
        chk("reset seq_a",    {31'd0, bus_a.seq_err}, 32'd0);
        chk("reset status_b", bus_b.status_out, 32'd0);
        $display("[TB] reset: mcnt=%h status=%h", bus_a.mcnt_out, bus_a.status_out);
        user_rst = 1'b0;
        step();

        // Table-driven vectors, one per cycle
        for (int i = 0; i < 24; i++) begin
            arm_r = vecs[i].arm;
            hv_r  = vecs[i].hv;
            pkt_r = vecs[i].pkt;
            step();
            chk($sformatf("vec%0d mcnt_a", i), bus_a.mcnt_out, vecs[i].mcnt);
            chk($sformatf("vec%0d status_a", i), bus_a.status_out,
                st(vecs[i].lock, vecs[i].armd, 1'b0, vecs[i].err_a, vecs[i].gap));
            chk($sformatf("vec%0d seq_a", i), {31'd0, bus_a.seq_err}, {31'd0, vecs[i].seq});
            chk($sformatf("vec%0d status_b", i), bus_b.status_out,
                st(vecs[i].lock, vecs[i].armd, 1'b0, vecs[i].err_b, vecs[i].gap));
            if (bus_a.seq_err) seq_a_cnt++;
            if (bus_b.seq_err) seq_b_cnt++;
            if (bus_b.seq_err && i >= 17 && i <= 21) sat_b_cnt++;
            $display("[TB] vec %0d: arm=%0b hv=%0b pkt=%0d mcnt=%h status=%h seq=%0b",
                     i, vecs[i].arm, vecs[i].hv, vecs[i].pkt, bus_a.mcnt_out,
                     bus_a.status_out, bus_a.seq_err);
        end
        arm_r = 1'b0;
        hv_r  = 1'b0;
        chk("seq pulses a", seq_a_cnt, 8);
        chk("seq pulses b", seq_b_cnt, 8);
        chk("sat burst pulses b", sat_b_cnt, 5);

        // Idle watchdog: 15 idle cycles keep lock, the 16th drops it when built in
        repeat (15) step();
        chk("wd 15 idle status_a", bus_a.status_out, st(1, 0, 0, 16'd7, 12'hFFE));
        step();
`ifdef LOOPBACK_MCNT_WATCHDOG_EN
        exp_wd = st(0, 1, 1, 16'd7, 12'hFFE);
`else
        exp_wd = st(1, 0, 0, 16'd7, 12'hFFE);
`endif
        chk("wd 16 idle status_a", bus_a.status_out, exp_wd);
        $display("[TB] watchdog idle: status=%h", bus_a.status_out);
        hv_r  = 1'b1;
        pkt_r = 48'd1001;
        step();
        hv_r  = 1'b0;
        chk("wd relock status_a", bus_a.status_out, st(1, 0, 0, 16'd7, 12'hFFE));
        chk("wd relock mcnt_a",   bus_a.mcnt_out, 32'd1001);
        chk("wd relock seq_a",    {31'd0, bus_a.seq_err}, 32'd0);
        $display("[TB] watchdog relock: mcnt=%h status=%h", bus_a.mcnt_out, bus_a.status_out);

        // Reset during a header, then headers without arm are ignored
        user_rst = 1'b1;
        hv_r     = 1'b1;
        pkt_r    = 48'd1002;
        step();
        chk("midrst mcnt_a",   bus_a.mcnt_out,   32'd0);
        chk("midrst status_a", bus_a.status_out, 32'd0);
        chk("midrst status_b", bus_b.status_out, 32'd0);
        user_rst = 1'b0;
        pkt_r    = 48'd1003;
        step();
        chk("post-rst ignore mcnt_a",   bus_a.mcnt_out,   32'd0);
        chk("post-rst ignore status_a", bus_a.status_out, 32'd0);
        $display("[TB] reset mid-packet: mcnt=%h status=%h", bus_a.mcnt_out, bus_a.status_out);
        arm_r = 1'b1;
        pkt_r = 48'd7;
        step();
        arm_r = 1'b0;
        chk("rearm mcnt_a",   bus_a.mcnt_out,   32'd7);
        chk("rearm status_a", bus_a.status_out, st(1, 0, 0, 16'd0, 12'h000));
        pkt_r = 48'd9;
        step();
        hv_r = 1'b0;
        chk("rearm gap status_a", bus_a.status_out, st(1, 0, 0, 16'd1, 12'h001));
        chk("rearm gap seq_a",    {31'd0, bus_a.seq_err}, 32'd1);
        $display("[TB] rearm: mcnt=%h status=%h", bus_a.mcnt_out, bus_a.status_out);
        step();
        chk("seq pulse width a", {31'd0, bus_a.seq_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
